// File: rtl/wasm_mem_arbiter_if.sv
// Bus bundle between the CPU and debug requesters, the arbiter and wasm_memory.
// The arbiter uses the slave modport. The environment (requesters and memory) uses the master modport.
interface wasm_mem_arbiter_if #(
  parameter int DATA_W = 64
);
  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic [2:0]        cpu_req_op;
  logic [31:0]       cpu_req_addr;
  logic [DATA_W-1:0] cpu_req_wdata;
  logic              cpu_rvalid;

  logic              dbg_req_valid;
  logic              dbg_req_ready;
  logic [2:0]        dbg_req_op;
  logic [31:0]       dbg_req_addr;
  logic [DATA_W-1:0] dbg_req_wdata;
  logic              dbg_rvalid;

  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [2:0]        mem_req_op;
  logic [31:0]       mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_err;

  logic              owner;
  logic              busy;

  modport slave (
    input  cpu_req_valid, cpu_req_op, cpu_req_addr, cpu_req_wdata,
    input  dbg_req_valid, dbg_req_op, dbg_req_addr, dbg_req_wdata,
    input  mem_req_ready, mem_rvalid, mem_rdata, mem_err,
    output cpu_req_ready, cpu_rvalid, dbg_req_ready, dbg_rvalid,
    output resp_rdata, resp_err,
    output mem_req_valid, mem_req_op, mem_req_addr, mem_req_wdata,
    output owner, busy
  );

  modport master (
    output cpu_req_valid, cpu_req_op, cpu_req_addr, cpu_req_wdata,
    output dbg_req_valid, dbg_req_op, dbg_req_addr, dbg_req_wdata,
    output mem_req_ready, mem_rvalid, mem_rdata, mem_err,
    input  cpu_req_ready, cpu_rvalid, dbg_req_ready, dbg_rvalid,
    input  resp_rdata, resp_err,
    input  mem_req_valid, mem_req_op, mem_req_addr, mem_req_wdata,
    input  owner, busy
  );
endinterface

// File: rtl/wasm_mem_arbiter.sv
// Two-requester (CPU / debug) arbiter in front of wasm_memory, one transaction outstanding.
// Define WASM_MEM_ARB_RR_EN for round-robin arbitration. Otherwise the CPU has fixed priority.
module wasm_mem_arbiter #(
  parameter int DATA_W = 64
) (
  input logic                clk,
  input logic                rst_n,
  wasm_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state_reg, state_next;
  logic              accept;
  logic              complete;
  logic              grant_dbg;

  logic [2:0]        op_reg;
  logic [31:0]       addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;
  logic              owner_reg;
  logic              cpu_rvalid_reg;
  logic              dbg_rvalid_reg;

`ifdef WASM_MEM_ARB_RR_EN
  // A value of 1 means that debug wins the next simultaneous contest.
  logic rr_ptr_reg;
  assign grant_dbg = bus.dbg_req_valid & (~bus.cpu_req_valid | rr_ptr_reg);
`else
  assign grant_dbg = bus.dbg_req_valid & ~bus.cpu_req_valid;
`endif

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.cpu_req_valid || bus.dbg_req_valid) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      op_reg         <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
      err_reg        <= 1'b0;
      owner_reg      <= 1'b0;
      cpu_rvalid_reg <= 1'b0;
      dbg_rvalid_reg <= 1'b0;
`ifdef WASM_MEM_ARB_RR_EN
      rr_ptr_reg     <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      cpu_rvalid_reg <= complete & ~owner_reg;
      dbg_rvalid_reg <= complete & owner_reg;
      if (accept) begin
        owner_reg <= grant_dbg;
        op_reg    <= grant_dbg ? bus.dbg_req_op    : bus.cpu_req_op;
        addr_reg  <= grant_dbg ? bus.dbg_req_addr  : bus.cpu_req_addr;
        wdata_reg <= grant_dbg ? bus.dbg_req_wdata : bus.cpu_req_wdata;
`ifdef WASM_MEM_ARB_RR_EN
        rr_ptr_reg <= ~grant_dbg;
`endif
      end
      if (complete) begin
        rdata_reg <= bus.mem_rdata;
        err_reg   <= bus.mem_err;
      end
    end
  end

  // The ready signals are gated by rst_n so that no request is acknowledged while reset is held.
  assign bus.cpu_req_ready = rst_n & accept & ~grant_dbg;
  assign bus.dbg_req_ready = rst_n & accept & grant_dbg;
  assign bus.cpu_rvalid    = cpu_rvalid_reg;
  assign bus.dbg_rvalid    = dbg_rvalid_reg;
  assign bus.resp_rdata    = rdata_reg;
  assign bus.resp_err      = err_reg;
  assign bus.mem_req_valid = (state_reg == ISSUE);
  assign bus.mem_req_op    = op_reg;
  assign bus.mem_req_addr  = addr_reg;
  assign bus.mem_req_wdata = wdata_reg;
  assign bus.owner         = owner_reg;
  assign bus.busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_wasm_mem_arbiter.sv
// Directed table-driven bench for wasm_mem_arbiter, plus hand-written reset and abort sequences.
// Contest expectations follow WASM_MEM_ARB_RR_EN when it is defined.
module tb_wasm_mem_arbiter;
  localparam int DATA_W = 64;
`ifdef WASM_MEM_ARB_RR_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wasm_mem_arbiter_if #(.DATA_W(DATA_W)) bus ();
  wasm_mem_arbiter #(.DATA_W(DATA_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        cpu_v;
    logic        dbg_v;
    logic [2:0]  cpu_op;
    logic [2:0]  dbg_op;
    logic [31:0] cpu_addr;
    logic [31:0] dbg_addr;
    logic [63:0] cpu_wdata;
    logic [63:0] dbg_wdata;
    int          stall;
    logic        spur;
    logic [63:0] rdata;
    logic        err;
    logic        exp_dbg;
    logic [2:0]  exp_op;
    logic [31:0] exp_addr;
    logic [63:0] exp_wdata;
  } vec_t;

  vec_t vt [8];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bus.cpu_req_valid = v.cpu_v;
    bus.cpu_req_op    = v.cpu_op;
    bus.cpu_req_addr  = v.cpu_addr;
    bus.cpu_req_wdata = v.cpu_wdata;
    bus.dbg_req_valid = v.dbg_v;
    bus.dbg_req_op    = v.dbg_op;
    bus.dbg_req_addr  = v.dbg_addr;
    bus.dbg_req_wdata = v.dbg_wdata;
    #1;
    check("cpu_req_ready", bus.cpu_req_ready, v.cpu_v & ~v.exp_dbg);
    check("dbg_req_ready", bus.dbg_req_ready, v.exp_dbg);
    @(posedge clk); @(negedge clk);
    // ISSUE: scramble the requester fields. The issued request must not change.
    bus.cpu_req_op    = ~v.cpu_op;
    bus.cpu_req_addr  = ~v.cpu_addr;
    bus.cpu_req_wdata = ~v.cpu_wdata;
    bus.dbg_req_op    = ~v.dbg_op;
    bus.dbg_req_addr  = ~v.dbg_addr;
    bus.dbg_req_wdata = ~v.dbg_wdata;
    bus.mem_rvalid    = v.spur;
    bus.mem_req_ready = (v.stall == 0);
    #1;
    check("busy_issue", bus.busy, 1'b1);
    check("owner", bus.owner, v.exp_dbg);
    check("mem_req_valid", bus.mem_req_valid, 1'b1);
    check("mem_req_op", bus.mem_req_op, v.exp_op);
    check("mem_req_addr", bus.mem_req_addr, v.exp_addr);
    check("mem_req_wdata", bus.mem_req_wdata, v.exp_wdata);
    check("ready_issue", {bus.cpu_req_ready, bus.dbg_req_ready}, 2'b00);
    check("rvalid_issue", {bus.cpu_rvalid, bus.dbg_rvalid}, 2'b00);
    for (int j = 0; j < v.stall; j++) begin
      @(posedge clk); @(negedge clk);
      bus.mem_rvalid = 1'b0;
      if (j == v.stall - 1) bus.mem_req_ready = 1'b1;
      #1;
      check("stall_mem_req_valid", bus.mem_req_valid, 1'b1);
      check("stall_mem_req_addr", bus.mem_req_addr, v.exp_addr);
      check("stall_ready", {bus.cpu_req_ready, bus.dbg_req_ready}, 2'b00);
      check("stall_rvalid", {bus.cpu_rvalid, bus.dbg_rvalid}, 2'b00);
    end
    @(posedge clk); @(negedge clk);
    // WAIT: memory completes in this cycle.
    bus.mem_req_ready = 1'b0;
    bus.mem_rvalid    = 1'b1;
    bus.mem_rdata     = v.rdata;
    bus.mem_err       = v.err;
    #1;
    check("mem_req_valid_wait", bus.mem_req_valid, 1'b0);
    check("busy_wait", bus.busy, 1'b1);
    check("rvalid_wait", {bus.cpu_rvalid, bus.dbg_rvalid}, 2'b00);
    @(posedge clk); @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = ~v.rdata;
    bus.mem_err    = ~v.err;
    #1;
    check("cpu_rvalid", bus.cpu_rvalid, v.cpu_v & ~v.exp_dbg);
    check("dbg_rvalid", bus.dbg_rvalid, v.exp_dbg);
    check("resp_err", bus.resp_err, v.err);
    if (!v.exp_op[2]) check("resp_rdata", bus.resp_rdata, v.rdata);
    check("busy_done", bus.busy, 1'b0);
    $display("[TB] vec %0d: grant=%s addr=0x%0h err=%0d rdata=0x%0h",
             idx, bus.dbg_rvalid ? "dbg" : "cpu", v.exp_addr, bus.resp_err, bus.resp_rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Contest vectors: the CPU reads and debug writes.
    vt[0] = '{1, 1, 3'b011, 3'b111, 32'h300, 32'h400, 64'h1111, 64'h2222, 0, 0, 64'hA0, 0,
              1'b0, 3'b011, 32'h300, 64'h1111};
    vt[1] = '{1, 1, 3'b011, 3'b111, 32'h304, 32'h404, 64'h1111, 64'h2222, 0, 0, 64'hA1, 0,
              RR, RR ? 3'b111 : 3'b011, RR ? 32'h404 : 32'h304, RR ? 64'h2222 : 64'h1111};
    vt[2] = '{1, 1, 3'b011, 3'b111, 32'h308, 32'h408, 64'h1111, 64'h2222, 0, 0, 64'hA2, 0,
              1'b0, 3'b011, 32'h308, 64'h1111};
    vt[3] = '{1, 1, 3'b011, 3'b111, 32'h30C, 32'h40C, 64'h1111, 64'h2222, 0, 0, 64'hA3, 0,
              RR, RR ? 3'b111 : 3'b011, RR ? 32'h40C : 32'h30C, RR ? 64'h2222 : 64'h1111};
    vt[4] = '{1, 0, 3'b010, 3'b000, 32'h100, 32'h0, 64'h0, 64'h0, 0, 0, 64'hDEADBEEF, 0,
              1'b0, 3'b010, 32'h100, 64'h0};
    vt[5] = '{0, 1, 3'b000, 3'b110, 32'h0, 32'h10000, 64'h0, 64'hCAFE, 0, 0, 64'h0, 1,
              1'b1, 3'b110, 32'h10000, 64'hCAFE};
    vt[6] = '{1, 0, 3'b001, 3'b000, 32'h200, 32'h0, 64'h77, 64'h0, 5, 1, 64'h0123456789ABCDEF, 0,
              1'b0, 3'b001, 32'h200, 64'h77};
    vt[7] = '{1, 1, 3'b000, 3'b101, 32'h600, 32'h700, 64'h5, 64'h6, 0, 0, 64'h55, 0,
              1'b0, 3'b000, 32'h600, 64'h5};

    bus.cpu_req_valid = 1'b1; bus.cpu_req_op = 3'b0; bus.cpu_req_addr = 32'h0; bus.cpu_req_wdata = '0;
    bus.dbg_req_valid = 1'b1; bus.dbg_req_op = 3'b0; bus.dbg_req_addr = 32'h0; bus.dbg_req_wdata = '0;
    bus.mem_req_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_err = 1'b0;

    // Reset is held while both requesters are valid. Nothing may be acknowledged.
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_ready", {bus.cpu_req_ready, bus.dbg_req_ready}, 2'b00);
    check("rst_rvalid", {bus.cpu_rvalid, bus.dbg_rvalid}, 2'b00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_owner", bus.owner, 1'b0);
    check("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
    check("rst_mem_req_addr", bus.mem_req_addr, 32'h0);
    check("rst_resp", {bus.resp_err, bus.resp_rdata}, 65'h0);
    bus.cpu_req_valid = 1'b0;
    bus.dbg_req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vt[i], i);
    bus.cpu_req_valid = 1'b0;
    bus.dbg_req_valid = 1'b0;
    @(posedge clk); @(negedge clk);

    // Debug read, then reset asserted during WAIT, then a late mem_rvalid arrives.
    bus.dbg_req_valid = 1'b1; bus.dbg_req_op = 3'b011; bus.dbg_req_addr = 32'h500;
    @(posedge clk); @(negedge clk);
    bus.dbg_req_valid = 1'b0; bus.mem_req_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.mem_req_ready = 1'b0;
    #1;
    check("abort_busy_wait", bus.busy, 1'b1);
    check("abort_owner_wait", bus.owner, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hBAD; bus.mem_err = 1'b1;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_owner", bus.owner, 1'b0);
    check("abort_mem_req_valid", bus.mem_req_valid, 1'b0);
    @(posedge clk); @(negedge clk);
    bus.mem_rvalid = 1'b0; bus.mem_err = 1'b0;
    #1;
    check("abort_rvalid_1", {bus.cpu_rvalid, bus.dbg_rvalid}, 2'b00);
    check("abort_busy_1", bus.busy, 1'b0);
    @(posedge clk); @(negedge clk); #1;
    check("abort_rvalid_2", {bus.cpu_rvalid, bus.dbg_rvalid}, 2'b00);

    // After reset, the CPU wins the contest in both builds.
    run_vec(vt[7], 7);
    bus.cpu_req_valid = 1'b0;
    bus.dbg_req_valid = 1'b0;
    @(posedge clk); @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wasm_mem_arbiter.md
WASM_MEM_ARBITER -- requirements
Module: wasm_mem_arbiter

Interface
REQ-001 DATA_W, default 64, width of request write data and response read data.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 cpu_req_valid  input  1  CPU requester has a memory operation pending.
REQ-005 cpu_req_ready  output  1  CPU request accepted this cycle.
REQ-006 cpu_req_op  input  3  bit2 write-enable, bits1:0 log2 access size in bytes.
REQ-007 cpu_req_addr  input  32  CPU byte address.
REQ-008 cpu_req_wdata  input  DATA_W  CPU write data.
REQ-009 cpu_rvalid  output  1  one-cycle completion pulse for the CPU transaction.
REQ-010 dbg_req_valid  input  1  debug/host requester has a memory operation pending.
REQ-011 dbg_req_ready  output  1  debug request accepted this cycle.
REQ-012 dbg_req_op  input  3  same encoding as cpu_req_op.
REQ-013 dbg_req_addr  input  32  debug byte address.
REQ-014 dbg_req_wdata  input  DATA_W  debug write data.
REQ-015 dbg_rvalid  output  1  one-cycle completion pulse for the debug transaction.
REQ-016 resp_rdata  output  DATA_W  shared read data; qualified by cpu_rvalid or dbg_rvalid.
REQ-017 resp_err  output  1  shared trap flag; qualified by cpu_rvalid or dbg_rvalid.
REQ-018 mem_req_valid  output  1  request to wasm_memory.
REQ-019 mem_req_ready  input  1  wasm_memory accepts the request.
REQ-020 mem_req_op / mem_req_addr / mem_req_wdata  output  3 / 32 / DATA_W  latched request fields.
REQ-021 mem_rvalid / mem_rdata / mem_err  input  1 / DATA_W / 1  memory completion, data and trap.
REQ-022 owner  output  1  0 = CPU, 1 = debug; meaningful only when busy.
REQ-023 busy  output  1  high in ISSUE and WAIT.

Function
REQ-024 The FSM SHALL use states IDLE, ISSUE and WAIT, with at most one transaction outstanding.
REQ-025 In IDLE with any req_valid, the block SHALL pick a winner, assert only that requester's req_ready for that cycle, latch its op/addr/wdata, set owner, and go to ISSUE.
REQ-026 req_ready SHALL be 0 in ISSUE and WAIT; a requester may drop valid before acceptance without effect.
REQ-027 In ISSUE, mem_req_valid SHALL be 1 with the latched fields held stable until mem_req_ready, then the FSM SHALL go to WAIT.
REQ-028 In WAIT, on mem_rvalid the block SHALL register mem_rdata/mem_err into resp_rdata/resp_err, pulse the owner's rvalid for exactly one cycle, and return to IDLE.
REQ-029 Writes SHALL complete the same way: memory acks with mem_rvalid, and resp_rdata is don't-care.
REQ-030 Minimum latency: accept at cycle N, mem_req_valid at N+1; with mem_rvalid at N+2, rvalid at N+3; the next acceptance is possible at N+3.
REQ-031 mem_rvalid in IDLE or ISSUE SHALL be ignored; the non-owner's rvalid SHALL never pulse.
REQ-032 mem_err SHALL be forwarded only, with no retry or stall; the arbiter continues normally.
REQ-033 Changes to requester fields after acceptance SHALL have no effect on the issued transaction.

Reset
REQ-034 With rst_n low at a clock edge: FSM goes to IDLE; all outputs are 0 (ready, rvalid, mem_req_*, resp_*, owner, busy); the round-robin pointer favours the CPU.
REQ-035 Reset during ISSUE/WAIT SHALL drop the transaction silently, with no rvalid pulse, and a late mem_rvalid SHALL be ignored.

Configuration
REQ-036 With WASM_MEM_ARB_RR_EN defined, arbitration SHALL be round-robin: after a grant to X, the other requester wins the next simultaneous contest.
REQ-037 Without WASM_MEM_ARB_RR_EN, the CPU SHALL always win simultaneous contests, and debug may starve.

Verification
REQ-038 Single CPU read addr 0x100, mem_req_ready=1, mem_rvalid the next cycle with rdata 0xDEADBEEF -> cpu_rvalid 1 cycle with resp_rdata 0xDEADBEEF, latency 3.
REQ-039 Both valid continuously for 4 transactions -> RR build grants cpu,dbg,cpu,dbg; fixed build grants cpu x4.
REQ-040 mem_req_ready low for 5 cycles -> mem_req_valid/addr stable all 5 cycles, no second acceptance.
REQ-041 dbg write 0x10000 with mem_err=1 -> dbg_rvalid with resp_err=1, cpu_rvalid 0, next request serviced.
REQ-042 rst_n low during WAIT, then mem_rvalid -> no rvalid pulse, busy=0, owner=0.
